codec_sample_capture: RTL
=========================

// Module: codec_sample_capture
// PURPOSE
//  Record-path counterpart of the playback conditioner: takes ADC samples from the ac97 codec
//  and delivers them to the 100MHz system logic. Detects the rising edge of new_frame and
//  captures codec_sample_in into a show-ahead FIFO. The system drains the FIFO with a
//  valid/ack handshake. Overflow is flagged, never silent.
// PARAMETERS
//  WIDTH          16  sample width in bits
//  ADDR_BITS      3   FIFO address bits; depth = 2**ADDR_BITS (8)
//  DROP_CNT_BITS  8   width of the saturating dropped-sample counter
// PORTS
//  clk              in   1               system clock
//  reset            in   1               asynchronous, active-low reset (0 = reset)
//  new_frame        in   1               from codec; rising edge marks a new received sample
//  codec_sample_in  in   WIDTH           ADC sample; stable on the cycle new_frame first reads 1
//  capture_enable   in   1               1 = accept samples; 0 = ignore frame edges
//  sample_out       out  WIDTH           oldest buffered sample (show-ahead)
//  sample_valid     out  1               sample_out holds a real sample
//  sample_ack       in   1               consume sample_out this cycle
//  fill_level       out  ADDR_BITS+1     number of samples buffered, 0..DEPTH
//  overflow         out  1               sticky: a sample was dropped because the FIFO was full
//  drop_count       out  DROP_CNT_BITS   saturating count of dropped samples
//  clear_overflow   in   1               clears overflow and drop_count
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty, sample_valid=0, fill_level=0, overflow=0, drop_count=0.
//   sample_out=0. Edge register prev_frame resets to 1, so new_frame held high across reset
//   release gives no capture.
//  Edge: frame_edge = new_frame & ~prev_frame. prev_frame <= new_frame every cycle.
//  push = frame_edge & capture_enable. pop = sample_ack & sample_valid.
//   sample_ack while sample_valid=0 is ignored.
//  Push: mem[wr_ptr] <= codec_sample_in; wr_ptr++. Pointers are ADDR_BITS+1 wide, wrap
//   mod 2*DEPTH. full when the addresses match and the MSBs differ. empty when the pointers
//   are equal.
//  Latency: a sample pushed into an empty FIFO gives sample_valid=1 and sample_out equal to
//   that sample on the next cycle.
//  sample_out = mem[rd_ptr[ADDR_BITS-1:0]] when not empty, else 0.
//   sample_valid = ~empty, registered-state derived.
//  Pop: rd_ptr++ at the clock edge. The next entry, if any, appears the following cycle
//   (back-to-back pops are allowed).
//  fill_level = wr_ptr - rd_ptr. It is updated on the same clock edge as the pointers.
//  Simultaneous push and pop, any fill level including full: both take effect and
//   fill_level is unchanged. When full, the pop frees the slot, so the push is accepted and
//   nothing is dropped.
//  Push while full without a pop: the new sample is dropped and FIFO contents are
//   unchanged. overflow <= 1 and drop_count++ (saturates at all-ones).
//  clear_overflow: overflow <= 0 and drop_count <= 0 next cycle.
//   If a drop happens in the same cycle, the drop wins: overflow=1, drop_count=1.
//  capture_enable=0: edges are detected but not pushed. Draining continues normally.
//   Toggling capture_enable never creates a spurious edge.
//  new_frame held high for many cycles produces exactly one push.
// TESTING
//  1 Reset with new_frame=1, release, hold for 5 cycles
//    -> no push; sample_valid=0, fill_level=0.
//  2 Three edges with samples 16'h1111, 16'h2222, 16'h3333, no ack
//    -> fill_level=3, sample_out=16'h1111.
//    Ack 3 consecutive cycles -> outputs 1111, 2222, 3333 in order, then sample_valid=0.
//  3 Ten edges with no ack (DEPTH=8)
//    -> fill_level=8, overflow=1, drop_count=2; drain yields the first 8 samples.
//  4 FIFO full, frame edge and sample_ack in the same cycle
//    -> fill_level stays 8, overflow stays 0, and the new sample is last out.
//  5 overflow=1 with drop_count=5: pulse clear_overflow -> both 0 next cycle.
//    clear_overflow coincident with a drop -> overflow=1, drop_count=1.
//  6 capture_enable=0 with 4 edges -> fill_level=0.
//    Assert reset mid-drain with fill_level=5 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/codec_sample_capture.sv
// Captures codec ADC samples on new_frame rising edges into a show-ahead FIFO drained by valid/ack.
// One cycle push-to-valid latency; a push into a full FIFO without a pop is dropped and counted.
module codec_sample_capture #(
  parameter int WIDTH         = 16,
  parameter int ADDR_BITS     = 3,
  parameter int DROP_CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     new_frame,
  input  logic [WIDTH-1:0]         codec_sample_in,
  input  logic                     capture_enable,
  output logic [WIDTH-1:0]         sample_out,
  output logic                     sample_valid,
  input  logic                     sample_ack,
  output logic [ADDR_BITS:0]       fill_level,
  output logic                     overflow,
  output logic [DROP_CNT_BITS-1:0] drop_count,
  input  logic                     clear_overflow
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]       PTR_ONE = 1;
  localparam logic [DROP_CNT_BITS-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_BITS:0] wr_ptr, rd_ptr;
  logic               prev_frame;

  logic frame_edge, push, pop, empty, full, accept, drop;

  always_comb begin
    frame_edge = new_frame & ~prev_frame;
    push       = frame_edge & capture_enable;
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]) &&
                 (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]);
    pop        = sample_ack & ~empty;
    // A pop on a full FIFO frees the slot in time for the coincident push.
    accept     = push & (~full | pop);
    drop       = push & full & ~pop;
  end

  // prev_frame resets high so a frame line already high at release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_frame <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      prev_frame <= new_frame;
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) begin
        overflow <= 1'b1;
        if (clear_overflow)        drop_count <= CNT_ONE;
        else if (drop_count != '1) drop_count <= drop_count + CNT_ONE;
      end else if (clear_overflow) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[ADDR_BITS-1:0]] <= codec_sample_in;
  end

  always_comb begin
    sample_valid = ~empty;
    sample_out   = empty ? '0 : mem[rd_ptr[ADDR_BITS-1:0]];
    fill_level   = wr_ptr - rd_ptr;
  end

endmodule
